// File: rtl/rx_serial_7o1_pkg.sv
// rtl/rx_serial_7o1_pkg.sv - shared constants and state encoding for the 7O1 serial receiver
// Package rx_serial_pkg: frame geometry and the 4-bit FSM state codes (also exposed on db_estado).
package rx_serial_pkg;

  localparam int DATA_BITS     = 7;
  localparam int FRAME_SAMPLES = 9;  // 7 data + parity + stop, sampled after the start bit

  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    ESPERA         = 4'd1,
    VERIFICA_START = 4'd2,
    RECEPCAO       = 4'd3,
    ARMAZENA       = 4'd4,
    FINAL          = 4'd5
  } estado_t;

endpackage

// File: rtl/rx_serial_7o1_if.sv
// rtl/rx_serial_7o1_if.sv - receiver-to-consumer character interface
// master: receiver side (drives character/status, reads limpa)
// slave : consumer side (reads character/status, drives limpa)
interface rx_serial_7o1_if;
  import rx_serial_pkg::*;

  logic                 limpa;
  logic [DATA_BITS-1:0] dados_ascii;
  logic                 paridade_ok;
  logic                 erro_parada;
  logic                 pronto;
  logic                 tem_dado;

  modport master (
    input  limpa,
    output dados_ascii, paridade_ok, erro_parada, pronto, tem_dado
  );

  modport slave (
    output limpa,
    input  dados_ascii, paridade_ok, erro_parada, pronto, tem_dado
  );

endinterface

// File: rtl/rx_serial_7o1_contador_m.sv
// rtl/rx_serial_7o1_contador_m.sv - modulo-M counter with synchronous clear and enable
// Ports: clock, reset (sync, active-high), zera (sync clear, wins over conta), conta (count enable),
//        fim (count == M-1), meio (count == M/2-1).
module contador_m #(
  parameter  int M = 9,
  localparam int W = (M > 1) ? $clog2(M) : 1
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim,
  output logic meio
);

  logic [W-1:0] cnt_q, cnt_d;

  assign fim  = (cnt_q == W'(M - 1));
  assign meio = (cnt_q == W'(M / 2 - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (zera)
      cnt_d = '0;
    else if (conta)
      cnt_d = fim ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rx_serial_7o1.sv
// rtl/rx_serial_7o1.sv - 7O1 asynchronous serial receiver (start, 7 data LSB-first, odd parity, stop)
// Ports: clock, reset (sync, active-high), dado_serial (async line, idle high),
//        rx (master: character, parity/stop status, pronto pulse, tem_dado level, limpa ack),
//        db_tick (sample strobe), db_dado_serial (synchronised line), db_estado (FSM state code).
// Option: RX_SERIAL_PARITY_CHECK_EN - when undefined paridade_ok is tied to 1.
module rx_serial_7o1 #(
  parameter int CLOCKS_PER_BIT = 434
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dado_serial,
  rx_serial_7o1_if.master   rx,
  output logic              db_tick,
  output logic              db_dado_serial,
  output logic [3:0]        db_estado
);
  import rx_serial_pkg::*;

  estado_t                    estado_q, estado_d;
  logic                       sync1_q, sync2_q, prev_q;
  logic [FRAME_SAMPLES-1:0]   sr_q, sr_d;
  logic [DATA_BITS-1:0]       dados_q, dados_d;
  logic                       par_q, par_d;
  logic                       erro_q, erro_d;
  logic                       tem_q, tem_d;
  logic                       pronto;
  logic                       tick_zera, tick_conta, tick_fim, tick_meio;
  logic                       bit_zera, bit_conta, bit_fim, bit_meio_unused;

  contador_m #(.M(CLOCKS_PER_BIT)) u_tick (
    .clock(clock), .reset(reset), .zera(tick_zera), .conta(tick_conta),
    .fim(tick_fim), .meio(tick_meio)
  );

  contador_m #(.M(FRAME_SAMPLES)) u_bit (
    .clock(clock), .reset(reset), .zera(bit_zera), .conta(bit_conta),
    .fim(bit_fim), .meio(bit_meio_unused)
  );

  always_comb begin
    estado_d   = estado_q;
    sr_d       = sr_q;
    dados_d    = dados_q;
    par_d      = par_q;
    erro_d     = erro_q;
    tick_zera  = 1'b0;
    tick_conta = 1'b0;
    bit_zera   = 1'b0;
    bit_conta  = 1'b0;
    db_tick    = 1'b0;
    pronto     = 1'b0;
    case (estado_q)
      INICIAL: begin
        tick_zera = 1'b1;
        bit_zera  = 1'b1;
        estado_d  = ESPERA;
      end
      ESPERA: begin
        tick_zera = 1'b1;
        bit_zera  = 1'b1;
        if (prev_q && !sync2_q) estado_d = VERIFICA_START;
      end
      VERIFICA_START: begin
        tick_conta = 1'b1;
        // Mid start bit: a high line here means the falling edge was a glitch.
        if (tick_meio) begin
          db_tick   = 1'b1;
          tick_zera = 1'b1;
          estado_d  = sync2_q ? ESPERA : RECEPCAO;
        end
      end
      RECEPCAO: begin
        tick_conta = 1'b1;
        if (tick_fim) begin
          db_tick   = 1'b1;
          bit_conta = 1'b1;
          // Shift in at the MSB so data lands in [6:0], parity in [7], stop in [8].
          sr_d      = {sync2_q, sr_q[FRAME_SAMPLES-1:1]};
          if (bit_fim) estado_d = ARMAZENA;
        end
      end
      ARMAZENA: begin
        dados_d  = sr_q[DATA_BITS-1:0];
`ifdef RX_SERIAL_PARITY_CHECK_EN
        par_d    = ^sr_q[DATA_BITS:0];
`else
        par_d    = 1'b1;
`endif
        erro_d   = ~sr_q[FRAME_SAMPLES-1];
        estado_d = FINAL;
      end
      FINAL: begin
        pronto   = 1'b1;
        estado_d = ESPERA;
      end
      default: estado_d = INICIAL;
    endcase
  end

`ifndef RX_SERIAL_PARITY_CHECK_EN
  logic parity_bit_unused;
  assign parity_bit_unused = sr_q[DATA_BITS];
`endif

  // Set in FINAL has priority over a simultaneous acknowledge.
  always_comb begin
    tem_d = tem_q;
    if (estado_q == FINAL) tem_d = 1'b1;
    else if (rx.limpa)     tem_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= INICIAL;
      sync1_q  <= 1'b1;  // idle level, so release from reset never looks like a start edge
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
      sr_q     <= '0;
      dados_q  <= '0;
`ifdef RX_SERIAL_PARITY_CHECK_EN
      par_q    <= 1'b0;
`else
      par_q    <= 1'b1;
`endif
      erro_q   <= 1'b0;
      tem_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      sync1_q  <= dado_serial;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      sr_q     <= sr_d;
      dados_q  <= dados_d;
      par_q    <= par_d;
      erro_q   <= erro_d;
      tem_q    <= tem_d;
    end
  end

  assign rx.dados_ascii  = dados_q;
  assign rx.paridade_ok  = par_q;
  assign rx.erro_parada  = erro_q;
  assign rx.pronto       = pronto;
  assign rx.tem_dado     = tem_q;
  assign db_dado_serial  = sync2_q;
  assign db_estado       = estado_q;

endmodule
